perf_counter_bank: RTL and testbench
====================================

// Module: perf_counter_bank
// PURPOSE
//   Parametrised performance-counter bank for the pipelined CPU. One free-running cycle counter
//   (channel 0) plus N_EVT event counters (branch, jump, load-use, ...). Counters stop at CPU halt.
//   A registered read mux returns any channel by index; the LOCK output follows halt.
//   Feeds the FPGA display/debug path.
// PARAMETERS
//   N_EVT     5   number of event counters; channels are 1..N_EVT
//   CNT_W     32  width of each counter, 8..64
//   SATURATE  0   0: counters wrap to 0 past all-ones; 1: counters hold at all-ones
//   SEL_W     localparam = $clog2(N_EVT+1), width of the channel index
// PORTS
//   clk      in   1          system clock; all logic on posedge
//   rst      in   1          asynchronous, active-high reset
//   halt     in   1          CPU halted
//   freeze   in   1          software freeze; no counter changes while high
//   clr      in   1          synchronous clear of all counters and ovf flags
//   evt      in   N_EVT      event strobes; evt[i] increments channel i+1, one count per cycle
//   sel      in   SEL_W      channel index for readback
//   rd_data  out  CNT_W      registered value of channel sel
//   cycles   out  CNT_W      live value of channel 0
//   ovf      out  N_EVT+1    sticky per-channel overflow flags
//   LOCK     out  1          = halt (combinational)
// BEHAVIOUR
//   - Reset (async) clears every counter, rd_data, cycles, ovf and snapshot registers, and sets state RUN.
//   - FSM, 2 states:
//       RUN    -> LOCKED when halt=1. The halt-entry cycle still counts channel 0 and events.
//       LOCKED -> RUN when halt=0. While LOCKED, channel 0 and all events are not counted.
//   - Increment enable:
//       channel 0: inc = (state==RUN) & ~freeze
//       channel i: inc = evt[i-1] & (state==RUN) & ~freeze
//   - Priority per cycle: rst > clr > inc. clr zeroes counters and ovf; events in that cycle are dropped.
//   - Overflow: an inc while a counter holds all-ones sets ovf[ch] (sticky until clr or rst).
//       SATURATE=0: the counter becomes 0.
//       SATURATE=1: the counter stays all-ones.
//   - Readback: rd_data <= counter[sel] at each posedge. rd_data is 1-cycle latency and shows the
//     pre-update value at the sampling edge. sel > N_EVT gives rd_data <= 0.
//   - cycles is combinational from the channel-0 register, so it is 0-latency.
//   - Simultaneous halt rising and freeze=1: no count, but the state still moves to LOCKED.
// CONFIGURATION
//   PERF_SNAPSHOT_EN defined:
//     - Adds ports snap (in 1) and rd_snap (in 1).
//     - snap=1 copies all channel registers (pre-update values) into shadow registers at the edge.
//       snap has priority over a simultaneous clr: the shadow gets the pre-clear values.
//     - rd_snap=1 makes rd_data read the shadow registers instead of the live counters.
//   PERF_SNAPSHOT_EN undefined: no snap/rd_snap ports, no shadow registers, rd_data is always live.
// STRUCTURE
//   - Package perf_pkg:
//       CNT_W default;
//       state enum {RUN, LOCKED};
//       channel constants CH_CYCLE=0, CH_UNCOND=1, CH_COND=2, CH_COND_OK=3, CH_LOADUSE=4.
//   - Sub-module perf_counter_cell (params CNT_W, SATURATE): inputs inc/clr; outputs cnt/ovf.
//     Instantiated N_EVT+1 times via generate.
//   - Top level holds the FSM, read mux/register and optional shadow bank.
// TESTING
//   1 Reset: rst=1 mid-count with cnt0=37 -> all counters, rd_data and ovf read 0 immediately (async).
//   2 Halt: run 10 cycles, halt=1 for 5 cycles, release -> cnt0=11 (entry cycle counted);
//     evt[0]=1 throughout gives ch1=11; LOCK high exactly while halt is high.
//   3 Wrap/saturate: CNT_W=8, 257 evt[2] pulses.
//     SATURATE=0 -> ch3=1, ovf[3]=1.  SATURATE=1 -> ch3=255, ovf[3]=1.
//   4 Clear race: clr=1 with evt all-ones and freeze=0 -> all channels 0 next cycle;
//     events in the clr cycle are not counted.
//   5 Readback: sel=2 with ch2=9 -> rd_data=9 one cycle later.
//     sel=7 (N_EVT=5) -> rd_data=0. freeze=1 for 4 cycles -> no counter changes.
//   6 Snapshot (PERF_SNAPSHOT_EN): ch1=20; pulse snap and clr together, rd_snap=1, sel=1
//     -> rd_data=20 while live ch1=0.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared types and constants for the performance-counter bank.
package perf_pkg;

  localparam int CNT_W_DEF = 32;

  typedef enum logic {
    RUN    = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Channel assignment used by the CPU pipeline
  localparam int CH_CYCLE   = 0;
  localparam int CH_UNCOND  = 1;
  localparam int CH_COND    = 2;
  localparam int CH_COND_OK = 3;
  localparam int CH_LOADUSE = 4;

endpackage

// File: rtl/perf_counter_cell.sv
// One counter channel: synchronous clear, increment, wrap or saturate, sticky overflow.
module perf_counter_cell
  import perf_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc) begin
      if (cnt_q == '1) begin
        ovf_d = 1'b1;
        cnt_d = (SATURATE != 0) ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Cycle counter (channel 0) plus N_EVT event counters with halt lock and registered readback.
// Optional shadow snapshot bank enabled by defining PERF_SNAPSHOT_EN.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter  int N_EVT    = 5,
  parameter  int CNT_W    = CNT_W_DEF,
  parameter  int SATURATE = 0,
  localparam int SEL_W    = $clog2(N_EVT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  input  logic             freeze,
  input  logic             clr,
  input  logic [N_EVT-1:0] evt,
  input  logic [SEL_W-1:0] sel,
`ifdef PERF_SNAPSHOT_EN
  input  logic             snap,
  input  logic             rd_snap,
`endif
  output logic [CNT_W-1:0] rd_data,
  output logic [CNT_W-1:0] cycles,
  output logic [N_EVT:0]   ovf,
  output logic             LOCK
);

  localparam int N_CH = N_EVT + 1;

  state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:    if (halt)  state_d = LOCKED;
      LOCKED: if (!halt) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  assign LOCK = halt;

  // The halt-entry cycle still counts because the enable looks at the registered state
  logic           run_en;
  logic [N_CH-1:0] inc;
  logic [CNT_W-1:0] cnt [N_CH];

  assign run_en = (state_q == RUN) && !freeze;
  assign inc    = {evt & {N_EVT{run_en}}, run_en};

  for (genvar g = 0; g < N_CH; g++) begin : g_cell
    perf_counter_cell #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .inc (inc[g]),
      .clr (clr),
      .cnt (cnt[g]),
      .ovf (ovf[g])
    );
  end

  assign cycles = cnt[CH_CYCLE];

  logic [CNT_W-1:0] src [N_CH];

`ifdef PERF_SNAPSHOT_EN
  logic [CNT_W-1:0] shadow_q [N_CH];

  // NOTE: the shadow bank is reset explicitly because it is observable through rd_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) shadow_q[i] <= '0;
    end else if (snap) begin
      for (int i = 0; i < N_CH; i++) shadow_q[i] <= cnt[i];
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) src[i] = rd_snap ? shadow_q[i] : cnt[i];
  end
`else
  always_comb begin
    for (int i = 0; i < N_CH; i++) src[i] = cnt[i];
  end
`endif

  // Out-of-range selects read as zero
  logic [CNT_W-1:0] rd_q, rd_d;

  always_comb begin
    rd_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel == SEL_W'(i)) rd_d = src[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_q <= '0;
    else     rd_q <= rd_d;
  end

  assign rd_data = rd_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: wrapping and saturating 8-bit instances driven in lockstep.
module tb_perf_counter_bank;
  import perf_pkg::*;

  localparam int N_EVT = 5;
  localparam int CNT_W = 8;
  localparam int SEL_W = $clog2(N_EVT + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             halt, freeze, clr;
  logic [N_EVT-1:0] evt;
  logic [SEL_W-1:0] sel;
  logic             snap, rd_snap;

  logic [CNT_W-1:0] rd_w, cyc_w, rd_s, cyc_s;
  logic [N_EVT:0]   ovf_w, ovf_s;
  logic             lock_w, lock_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  perf_counter_bank #(.N_EVT(N_EVT), .CNT_W(CNT_W), .SATURATE(0)) u_wrap (
    .clk     (clk),
    .rst     (rst),
    .halt    (halt),
    .freeze  (freeze),
    .clr     (clr),
    .evt     (evt),
    .sel     (sel),
`ifdef PERF_SNAPSHOT_EN
    .snap    (snap),
    .rd_snap (rd_snap),
`endif
    .rd_data (rd_w),
    .cycles  (cyc_w),
    .ovf     (ovf_w),
    .LOCK    (lock_w)
  );

  perf_counter_bank #(.N_EVT(N_EVT), .CNT_W(CNT_W), .SATURATE(1)) u_sat (
    .clk     (clk),
    .rst     (rst),
    .halt    (halt),
    .freeze  (freeze),
    .clr     (clr),
    .evt     (evt),
    .sel     (sel),
`ifdef PERF_SNAPSHOT_EN
    .snap    (snap),
    .rd_snap (rd_snap),
`endif
    .rd_data (rd_s),
    .cycles  (cyc_s),
    .ovf     (ovf_s),
    .LOCK    (lock_s)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; halt = 1'b0; freeze = 1'b0; clr = 1'b0;
    evt = '0; sel = '0; snap = 1'b0; rd_snap = 1'b0;

    // Reset state
    step(2);
    check("reset_cycles_w", cyc_w, 0);
    check("reset_rd_w", rd_w, 0);
    check("reset_ovf_w", ovf_w, 0);
    check("reset_lock", lock_w, 0);
    rst = 1'b0;

    // Async reset mid-count at cnt0=37
    step(37);
    check("pre_rst_cycles_w", cyc_w, 37);
    check("pre_rst_cycles_s", cyc_s, 37);
    check("pre_rst_rd_w", rd_w, 36);
    #2 rst = 1'b1;
    #1;
    check("async_rst_cycles_w", cyc_w, 0);
    check("async_rst_cycles_s", cyc_s, 0);
    check("async_rst_rd_w", rd_w, 0);
    check("async_rst_ovf_w", ovf_w, 0);
    rst = 1'b0;
    step(1);
    check("restart_cycles_w", cyc_w, 1);

    // Halt: 10 run cycles, 5 halted (entry counted), release
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("clr_cycles_w", cyc_w, 0);
    evt = 5'b00001;
    step(10);
    check("run10_cycles_w", cyc_w, 10);
    halt = 1'b1;
    #1;
    check("lock_high_w", lock_w, 1);
    check("lock_high_s", lock_s, 1);
    step(5);
    check("halted_cycles_w", cyc_w, 11);
    check("halted_lock_w", lock_w, 1);
    halt = 1'b0;
    #1;
    check("lock_low_w", lock_w, 0);
    step(1);
    check("release_cycles_w", cyc_w, 11);
    sel = 3'd1;
    step(1);
    check("halt_ch1_rd_w", rd_w, 11);
    check("halt_ch1_rd_s", rd_s, 11);
    check("resume_cycles_w", cyc_w, 12);
    evt = '0;

    // Readback: ch2=9, out-of-range select, freeze
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    evt = 5'b00010;
    step(9);
    evt = '0;
    sel = 3'd2;
    step(1);
    check("rd_ch2_w", rd_w, 9);
    sel = 3'd7;
    step(1);
    check("rd_sel7_w", rd_w, 0);
    check("rd_sel7_s", rd_s, 0);
    freeze = 1'b1;
    evt = '1;
    sel = 3'd2;
    step(1);
    check("freeze_start_cycles_w", cyc_w, 11);
    step(3);
    check("freeze_cycles_w", cyc_w, 11);
    check("freeze_rd_ch2_w", rd_w, 9);
    freeze = 1'b0;
    evt = '0;

    // Clear race: clr with all events high
    evt = '1;
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    evt = '0;
    freeze = 1'b1;
    check("clr_race_cycles_w", cyc_w, 0);
    check("clr_race_ovf_w", ovf_w, 0);
    for (int ch = 1; ch <= N_EVT; ch++) begin
      sel = SEL_W'(ch);
      step(1);
      check($sformatf("clr_race_ch%0d_w", ch), rd_w, 0);
    end
    freeze = 1'b0;

    // Wrap vs saturate: 257 pulses on evt[2]
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    evt = 5'b00100;
    step(257);
    evt = '0;
    freeze = 1'b1;
    sel = 3'd3;
    step(1);
    check("wrap_ch3", rd_w, 1);
    check("sat_ch3", rd_s, 255);
    check("wrap_cycles", cyc_w, 1);
    check("sat_cycles", cyc_s, 255);
    check("wrap_ovf", ovf_w, 6'b001001);
    check("sat_ovf", ovf_s, 6'b001001);
    freeze = 1'b0;

`ifdef PERF_SNAPSHOT_EN
    // Snapshot taken in the same cycle as clr keeps pre-clear values
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    evt = 5'b00001;
    step(20);
    evt = '0;
    snap = 1'b1;
    clr = 1'b1;
    step(1);
    snap = 1'b0;
    clr = 1'b0;
    freeze = 1'b1;
    rd_snap = 1'b1;
    sel = 3'd1;
    step(1);
    check("snap_ch1_w", rd_w, 20);
    check("snap_ch1_s", rd_s, 20);
    rd_snap = 1'b0;
    step(1);
    check("live_ch1_w", rd_w, 0);
    freeze = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
